// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status engine: mode encoding and the
// power-on channel configuration (legacy 1 Hz / 50 % blink).
package led_status_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PULSE   = 3'd3,
    MODE_ONESHOT = 3'd4
  } mode_e;

  localparam int PULSE_MS_DEF = 150;
  localparam int RST_PERIOD   = 1000;
  localparam int RST_DUTY     = 500;

  // Unused codes 5..7 collapse to OFF when latched.
  function automatic mode_e decode_mode(input logic [2:0] code);
    mode_e m;
    m = (code > 3'd4) ? MODE_OFF : mode_e'(code);
    return m;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, ms counters and mode FSM.
// o_led is computed from the registered state, so it trails that state by one edge.
module led_channel
  import led_status_pkg::*;
#(
  parameter int T_W      = 16,
  parameter int PULSE_MS = PULSE_MS_DEF
) (
  input  logic           i_clk,
  input  logic           i_n_reset,
  input  logic           i_tick,
  input  logic           i_we,
  input  logic [2:0]     i_mode,
  input  logic [T_W-1:0] i_period,
  input  logic [T_W-1:0] i_duty,
  input  logic           i_event,
  output logic           o_led
);

  localparam logic [T_W-1:0] ONE      = T_W'(1);
  localparam logic [T_W-1:0] PULSE_ON = T_W'(PULSE_MS);
  localparam logic [T_W-1:0] PAIR_END = T_W'(2 * PULSE_MS - 1);

  mode_e          mode_q, mode_d;
  logic [T_W-1:0] period_q, period_d;
  logic [T_W-1:0] duty_q, duty_d;
  logic [T_W-1:0] cnt_q, cnt_d;
  logic [T_W-1:0] pcnt_q, pcnt_d;
  logic           gap_q, gap_d;
  logic           led_q, led_d;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      mode_q   <= MODE_BLINK;
      period_q <= T_W'(RST_PERIOD);
      duty_q   <= T_W'(RST_DUTY);
      cnt_q    <= '0;
      pcnt_q   <= '0;
      gap_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      gap_q    <= gap_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    gap_d    = gap_q;
    led_d    = 1'b0;

    case (mode_q)
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = (period_q == '0) ? (duty_q != '0) : (cnt_q < duty_q);
      MODE_PULSE:   led_d = (duty_q != '0) && !gap_q && (cnt_q < PULSE_ON);
      MODE_ONESHOT: led_d = (cnt_q != '0);
      default:      led_d = 1'b0;
    endcase

    // A write restarts the channel and swallows a coincident tick.
    if (i_we) begin
      mode_d   = decode_mode(i_mode);
      period_d = i_period;
      duty_d   = i_duty;
      cnt_d    = '0;
      pcnt_d   = '0;
      gap_d    = 1'b0;
    end else if (i_tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (period_q != '0) cnt_d = (cnt_q == period_q - ONE) ? '0 : cnt_q + ONE;
        end
        MODE_PULSE: begin
          if (duty_q != '0) begin
            if (gap_q) begin
              if (cnt_q == period_q - ONE) begin
                cnt_d = '0;
                gap_d = 1'b0;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else if (cnt_q == PAIR_END) begin
              cnt_d = '0;
              if (pcnt_q == duty_q - ONE) begin
                pcnt_d = '0;
                gap_d  = (period_q != '0);
              end else begin
                pcnt_d = pcnt_q + ONE;
              end
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          if (cnt_q != '0) cnt_d = cnt_q - ONE;
        end
        default: ;
      endcase
    end

    // Event is evaluated against the post-write config so a ONESHOT write can fire at once.
    if (i_event && (mode_d == MODE_ONESHOT) && (period_d != '0)) cnt_d = period_d;
  end

  assign o_led = led_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED indicator engine: shared 1 ms prescaler, config write
// decode, and N_LEDS independent led_channel instances.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int N_LEDS   = 4,
  parameter int T_W      = 16,
  parameter int PULSE_MS = PULSE_MS_DEF
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  input  logic              i_cfg_we,
  input  logic [3:0]        i_cfg_ch,
  input  logic [2:0]        i_cfg_mode,
  input  logic [T_W-1:0]    i_cfg_period,
  input  logic [T_W-1:0]    i_cfg_duty,
  input  logic [N_LEDS-1:0] i_event,
  output logic [N_LEDS-1:0] o_led,
  output logic              o_tick
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic              tick;
  logic [N_LEDS-1:0] we_vec;

  assign tick = (presc_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PS_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) presc_q <= '0;
    else            presc_q <= presc_d;
  end

  // Channels at or above N_LEDS never match, so such writes fall on the floor.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < N_LEDS; i++) we_vec[i] = i_cfg_we && (i_cfg_ch == 4'(i));
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
    led_channel #(
      .T_W      (T_W),
      .PULSE_MS (PULSE_MS)
    ) u_ch (
      .i_clk    (i_clk),
      .i_n_reset(i_n_reset),
      .i_tick   (tick),
      .i_we     (we_vec[gi]),
      .i_mode   (i_cfg_mode),
      .i_period (i_cfg_period),
      .i_duty   (i_cfg_duty),
      .i_event  (i_event[gi]),
      .o_led    (o_led[gi])
    );
  end

  assign o_tick = tick;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: arithmetic reference model checked every cycle,
// a table of static config vectors, and hand-timed multi-cycle sequences.
module tb_led_status_ctrl;

  localparam int CLK_HZ   = 10000;
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int N_LEDS   = 4;
  localparam int T_W      = 16;
  localparam int PULSE_MS = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           we    = 1'b0;
  logic [3:0]     ch    = '0;
  logic [2:0]     mode  = '0;
  logic [T_W-1:0] per   = '0;
  logic [T_W-1:0] duty  = '0;
  logic [3:0]     ev    = '0;
  logic [3:0]     led;
  logic           tick;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .CLK_HZ(CLK_HZ), .N_LEDS(N_LEDS), .T_W(T_W), .PULSE_MS(PULSE_MS)
  ) dut (
    .i_clk(clk), .i_n_reset(rst_n), .i_cfg_we(we), .i_cfg_ch(ch),
    .i_cfg_mode(mode), .i_cfg_period(per), .i_cfg_duty(duty),
    .i_event(ev), .o_led(led), .o_tick(tick)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: ticks elapsed since the last write, evaluated with modulo arithmetic.
  int         m_mode[4], m_per[4], m_duty[4], m_n[4], m_rem[4];
  int         m_clk;
  logic [3:0] exp_led;

  function automatic logic model_led(input int c);
    int cyc, pos;
    case (m_mode[c])
      1: return 1'b1;
      2: begin
        if (m_per[c] == 0) return m_duty[c] != 0;
        return (m_n[c] % m_per[c]) < m_duty[c];
      end
      3: begin
        if (m_duty[c] == 0) return 1'b0;
        cyc = m_duty[c] * 2 * PULSE_MS + m_per[c];
        pos = m_n[c] % cyc;
        return (pos < m_duty[c] * 2 * PULSE_MS) && ((pos % (2 * PULSE_MS)) < PULSE_MS);
      end
      4: return m_rem[c] > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_mode[c] = 2; m_per[c] = 1000; m_duty[c] = 500; m_n[c] = 0; m_rem[c] = 0;
    end
    m_clk   = 0;
    exp_led = '0;
  endtask

  initial begin : model
    bit t;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        t = (m_clk % TICK_DIV) == TICK_DIV - 1;
        m_clk++;
        for (int c = 0; c < 4; c++) exp_led[c] = model_led(c);
        for (int c = 0; c < 4; c++) begin
          if (we && ch == c) begin
            m_mode[c] = int'(mode); m_per[c] = int'(per); m_duty[c] = int'(duty);
            m_n[c] = 0; m_rem[c] = 0;
          end else if (t) begin
            m_n[c]++;
            if (m_rem[c] > 0) m_rem[c]--;
          end
          if (ev[c] && m_mode[c] == 4 && m_per[c] != 0) m_rem[c] = m_per[c];
        end
      end
    end
  end

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      check("sb_led", led, rst_n ? exp_led : 4'h0);
      check("sb_tick", tick, rst_n && ((m_clk % TICK_DIV) == TICK_DIV - 1));
    end
  end

  task automatic do_write(input logic [3:0] c, input logic [2:0] md, input int p, input int d);
    @(negedge clk);
    we = 1'b1; ch = c; mode = md; per = T_W'(p); duty = T_W'(d);
    @(negedge clk);
    we = 1'b0;
  endtask

  // Leaves the caller at the falling edge inside a tick cycle.
  task automatic sync_tick();
    int k;
    k = 0;
    @(negedge clk);
    while (!tick && k < 2 * TICK_DIV) begin
      @(negedge clk);
      k++;
    end
    check("sync_tick", tick, 1'b1);
  endtask

  // Called right after reset release at a falling edge.
  task automatic post_reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_led_edge1"}, led, 4'hF);
    repeat (7) @(negedge clk);
    check({tag, "_tick_edge8"}, tick, 1'b0);
    @(negedge clk);
    check({tag, "_tick_edge9"}, tick, 1'b1);
    repeat (4991) @(negedge clk);
    check({tag, "_led_edge5000"}, led, 4'hF);
    @(negedge clk);
    check({tag, "_led_edge5001"}, led, 4'h0);
  endtask

  typedef struct {
    logic [3:0] ch;
    logic [2:0] mode;
    int         per;
    int         duty;
    logic [3:0] mask;
    logic [3:0] exp;
  } vec_t;

  vec_t        tbl[11];
  logic [63:0] got64, exp64;

  initial begin : main
    tbl[0]  = '{4'd1,  3'd2, 4,  6, 4'b0010, 4'b0010};
    tbl[1]  = '{4'd1,  3'd2, 0,  0, 4'b0010, 4'b0000};
    tbl[2]  = '{4'd1,  3'd2, 0,  3, 4'b0010, 4'b0010};
    tbl[3]  = '{4'd2,  3'd1, 0,  0, 4'b0110, 4'b0110};
    tbl[4]  = '{4'd3,  3'd6, 9,  9, 4'b1110, 4'b0110};
    tbl[5]  = '{4'd2,  3'd0, 0,  0, 4'b1110, 4'b0010};
    tbl[6]  = '{4'd7,  3'd1, 0,  0, 4'b1110, 4'b0010};
    tbl[7]  = '{4'd3,  3'd1, 0,  0, 4'b1110, 4'b1010};
    tbl[8]  = '{4'd15, 3'd0, 0,  0, 4'b1110, 4'b1010};
    tbl[9]  = '{4'd2,  3'd2, 5,  5, 4'b1110, 4'b1110};
    tbl[10] = '{4'd3,  3'd4, 5,  0, 4'b1110, 4'b0110};

    repeat (3) @(negedge clk);
    check("reset_led", led, 4'h0);
    check("reset_tick", tick, 1'b0);
    rst_n = 1'b1;
    post_reset_checks("por");
    repeat (4999) @(negedge clk);
    check("por_led_edge10000", led, 4'h0);
    @(negedge clk);
    check("por_led_edge10001", led, 4'hF);

    for (int i = 0; i < 11; i++) begin
      do_write(tbl[i].ch, tbl[i].mode, tbl[i].per, tbl[i].duty);
      repeat (30) @(negedge clk);
      check($sformatf("tbl%0d", i), led & tbl[i].mask, tbl[i].exp);
    end

    // PULSE: 3 x (2 on, 2 off) then 20 off, sampled once per tick.
    sync_tick();
    do_write(4'd2, 3'd3, 20, 3);
    got64 = '0; exp64 = '0;
    for (int k = 0; k < 64; k++) begin
      int j;
      j = 0;
      do begin
        @(negedge clk);
        j++;
      end while (!tick && j < 2 * TICK_DIV);
      got64[k] = led[2];
      exp64[k] = ((k % 32) < 12) && ((k % 4) < 2);
    end
    check("pulse_pattern", got64, exp64);

    // ONESHOT period 5, events at tick 0 and tick 3 (cycle offsets from tick cycle T).
    sync_tick();
    do_write(4'd3, 3'd4, 5, 0);
    ev = 4'b1000;
    for (int c = 3; c <= 82; c++) begin
      @(negedge clk);
      ev = (c == 32) ? 4'b1000 : 4'b0000;
      if (c == 3)  check("oneshot_before", led[3], 1'b0);
      if (c == 4)  check("oneshot_on", led[3], 1'b1);
      if (c == 81) check("oneshot_extended", led[3], 1'b1);
      if (c == 82) check("oneshot_off", led[3], 1'b0);
    end

    do_write(4'd3, 3'd4, 0, 0);
    ev = 4'b1000;
    repeat (4) @(negedge clk);
    ev = 4'b0000;
    check("oneshot_p0_ignored", led[3], 1'b0);

    @(negedge clk);
    we = 1'b1; ch = 4'd3; mode = 3'd4; per = T_W'(3); duty = '0; ev = 4'b1000;
    @(negedge clk);
    we = 1'b0; ev = 4'b0000;
    @(negedge clk);
    check("wr_ev_same_cycle", led[3], 1'b1);

    // Write landing in a tick cycle: counter must restart from 0.
    sync_tick();
    we = 1'b1; ch = 4'd1; mode = 3'd2; per = T_W'(2); duty = T_W'(1);
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    check("wr_tick_led_t2", led[1], 1'b1);
    repeat (9) @(negedge clk);
    check("wr_tick_led_t11", led[1], 1'b1);
    @(negedge clk);
    check("wr_tick_led_t12", led[1], 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      we   = ($urandom_range(0, 7) == 0);
      ch   = 4'($urandom_range(0, 8));
      mode = 3'($urandom_range(0, 7));
      per  = T_W'($urandom_range(0, 12));
      duty = T_W'($urandom_range(0, 6));
      ev   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    we = 1'b0; ev = '0;

    // Reset in the middle of PULSE operation.
    do_write(4'd2, 3'd3, 20, 3);
    do_write(4'd1, 3'd1, 0, 0);
    repeat (50) @(negedge clk);
    check("pre_reset_ch1_on", led[1], 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_led", led, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post_reset_checks("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised multi-channel LED indicator engine that replaces the fixed 1 s / 50 % free-running blinker in the top level. A shared prescaler derives a 1 ms tick from `i_clk`. N independent channels each run one of five modes (off, on, blink, pulse-code, one-shot) with runtime-writable period and duty. Configuration comes from the command-packet decoder over a single-cycle write port; one-shot events come from miner/UART status strobes.

## Interface
- `CLK_HZ`, 100000000, input clock frequency; `TICK_DIV = CLK_HZ/1000`, must be ≥ 2.
- `N_LEDS`, 4, number of channels, 1..16.
- `T_W`, 16, width of period/duty fields in ms ticks.
- `PULSE_MS`, 150, on-time and off-time of each pulse in pulse-code mode.
- `i_clk`  in  1  system clock.
- `i_n_reset`  in  1  reset, asynchronous, active-low.
- `i_cfg_we`  in  1  config write strobe; one write per asserted cycle.
- `i_cfg_ch`  in  4  target channel; values ≥ `N_LEDS` are ignored.
- `i_cfg_mode`  in  3  mode code.
- `i_cfg_period`  in  `T_W`  period / gap / one-shot length, ms.
- `i_cfg_duty`  in  `T_W`  blink on-time in ms, or pulse count in pulse-code mode.
- `i_event`  in  `N_LEDS`  per-channel one-shot trigger, level-sampled each clock.
- `o_led`  out  `N_LEDS`  registered LED drive, active-high.
- `o_tick`  out  1  1 ms tick strobe, one cycle wide, for reuse by other blocks.

## Operation
- Mode codes: 0 OFF, 1 ON, 2 BLINK, 3 PULSE, 4 ONESHOT. Codes 5–7 are treated as OFF.
- Prescaler counts 0..`TICK_DIV`-1. `o_tick`=1 in the cycle the count equals `TICK_DIV`-1.
- Per channel: `cnt` (`T_W` bits) and, for PULSE, `pcnt` (pulse index) plus `gap` flag.
- OFF: `o_led`=0, counters held at 0.
- ON: `o_led`=1.
- BLINK:
  - `cnt` increments on tick and wraps to 0 when `cnt`=`period`-1.
  - `o_led` = (`cnt` < `duty`).
  - `period`=0 → `o_led` = (`duty`≠0), static.
  - `duty` ≥ `period` → constantly on.
- PULSE:
  - Emits `duty` pulses, each `PULSE_MS` on then `PULSE_MS` off, followed by a `period`-ms gap (LED off), then repeats.
  - `duty`=0 → constantly off.
  - `period`=0 → no gap.
- ONESHOT:
  - `i_event` high loads `cnt`=`period` and sets `o_led`=1.
  - `cnt` decrements on tick; LED drops when `cnt` reaches 0.
  - Retrigger while active reloads `cnt` (extends).
  - `period`=0 → event ignored.
- Config write: if `i_cfg_ch` < `N_LEDS`, latches mode/period/duty into that channel and clears `cnt`, `pcnt`, `gap`. The new mode governs `o_led` from the next edge.
- Write and tick in the same cycle: the write wins; counters are cleared and the tick is not applied to that channel.
- Write and event in the same cycle on a ONESHOT write: the event is applied after the load (LED on, `cnt`=new `period`).

## Timing
- Reset values:
  - `o_led`=0; `o_tick`=0; prescaler=0; all counters 0.
  - Every channel reset config: mode BLINK, `period`=1000, `duty`=500. This reproduces the legacy 1 Hz blink.
- Latency:
  - `o_led` is registered: a config write or event at edge k is visible on `o_led` after edge k+1.
  - Tick-driven transitions appear on the edge after `o_tick` is high.
- First `o_tick` occurs `TICK_DIV` clocks after reset release.
- With reset config, `o_led` goes 1 on the first edge after release, 0 after 500 ticks, and 1 again after 1000 ticks.
- Reset asserted mid-operation immediately returns all state to reset values, including the channel config.
- No handshake: writes are always accepted; there is no ready signal.

## Structure
- Package `led_status_pkg`: mode encoding constants, `PULSE_MS` default, and reset period/duty constants.
- Sub-module `led_channel`: one channel's config registers, counters and mode FSM, generated `N_LEDS` times.
- Prescaler and the write-address decode live in `led_status_ctrl`.
- Target size: ~250 lines total.

## Test plan
Run with `CLK_HZ`=10000, so `TICK_DIV`=10.
- Reset release, no writes → `o_led[0]` high for 500 ticks (5000 clocks), low for 500, period 10000 clocks; all channels identical; `o_tick` every 10 clocks.
- Write ch1 BLINK `period`=4 `duty`=6, then `period`=0 `duty`=0 → constantly high, then constantly low; ch0 undisturbed.
- Write ch2 PULSE `duty`=3 `period`=20, `PULSE_MS`=2 → pattern of 3×(2 on, 2 off) then 20 off, repeating with a 32-tick cycle.
- Write ch3 ONESHOT `period`=5, pulse `i_event[3]` at tick 0 and again at tick 3 → LED high from next edge until tick 8; an event with `period`=0 leaves the LED low.
- Write with `i_cfg_ch`=7 (`N_LEDS`=4) → no state change; write coinciding with `o_tick` → counter cleared, no tick applied.
- Assert `i_n_reset` mid-PULSE → `o_led`=0 asynchronously; after release all channels revert to BLINK 1000/500.
